// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU and its sequential multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } op_t;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH bits kept.
// start stays high while the owning stage holds the MUL and is not advancing it.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t       state_r;
  mul_state_t       state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] prod_r;
  logic             last_s;

  assign last_s  = (cnt_r == CW'(WIDTH - 1));
  assign done    = (state_r == MUL_DONE);
  assign product = prod_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; DONE falls back to IDLE once the owner advances
  always_comb begin
    state_s = state_r;
    case (state_r)
      MUL_IDLE: begin
        if (start) state_s = MUL_BUSY;
        else       state_s = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (last_s) state_s = MUL_DONE;
        else        state_s = MUL_BUSY;
      end
      MUL_DONE: begin
        if (start) state_s = MUL_DONE;
        else       state_s = MUL_IDLE;
      end
      default: state_s = MUL_IDLE;
    endcase
  end

  // Counter and partial-product accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      prod_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        MUL_IDLE: begin
          cnt_r  <= {CW{1'b0}};
          prod_r <= {WIDTH{1'b0}};
        end
        MUL_BUSY: begin
          if (b[cnt_r]) prod_r <= prod_r + (a << cnt_r);
          else          prod_r <= prod_r;
          cnt_r <= cnt_r + 1'b1;
        end
        MUL_DONE: begin
          cnt_r  <= cnt_r;
          prod_r <= prod_r;
        end
        default: begin
          cnt_r  <= {CW{1'b0}};
          prod_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready handshakes, NZCV flags, tag pass-through and a
// multi-cycle MUL that stalls stage 1 until the sequential multiplier finishes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] tag_out,
  output logic [3:0]       flags_out
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int M  = WIDTH - 1;

  logic             s1_valid_r;
  logic [3:0]       s1_op_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;
  logic             s1_finished_s;
  logic             s1_advance_s;
  logic             accept_s;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [SW-1:0]    shamt_s;
  logic [WIDTH-1:0] res_s;
  logic [3:0]       flags_s;
  logic             c_s;
  logic             v_s;
  logic             nop_s;

  assign is_mul_s      = (s1_op_r == OP_MUL);
  assign s1_finished_s = s1_valid_r && (!is_mul_s || mul_done_s);
  assign s1_advance_s  = s1_finished_s && (!out_valid || out_ready);
  assign in_ready      = !s1_valid_r || s1_advance_s;
  assign accept_s      = in_valid && in_ready;
  assign mul_start_s   = s1_valid_r && is_mul_s && !s1_advance_s;

  assign sum_s   = {1'b0, s1_a_r} + {1'b0, s1_b_r};
  assign diff_s  = {1'b0, s1_a_r} - {1'b0, s1_b_r};
  assign shamt_s = s1_b_r[SW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (s1_a_r),
    .b       (s1_b_r),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Stage 1 operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'd0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= op_in;
      s1_a_r     <= a_in;
      s1_b_r     <= b_in;
      s1_tag_r   <= tag_in;
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Operation decode, result and flag generation; unknown codes act as NOP
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    nop_s = 1'b0;
    case (s1_op_r)
      OP_ADD: begin
        res_s = sum_s[M:0];
        c_s   = sum_s[WIDTH];
        v_s   = (s1_a_r[M] == s1_b_r[M]) && (sum_s[M] != s1_a_r[M]);
      end
      OP_SUB: begin
        res_s = diff_s[M:0];
        c_s   = !diff_s[WIDTH];
        v_s   = (s1_a_r[M] != s1_b_r[M]) && (diff_s[M] != s1_a_r[M]);
      end
      OP_AND:  res_s = s1_a_r & s1_b_r;
      OP_OR:   res_s = s1_a_r | s1_b_r;
      OP_XOR:  res_s = s1_a_r ^ s1_b_r;
      OP_SLL:  res_s = s1_a_r << shamt_s;
      OP_SRL:  res_s = s1_a_r >> shamt_s;
      OP_SRA:  res_s = $signed(s1_a_r) >>> shamt_s;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(s1_a_r) < $signed(s1_b_r))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (s1_a_r < s1_b_r)};
      OP_MUL:  res_s = mul_product_s;
      OP_NOP:  nop_s = 1'b1;
      default: nop_s = 1'b1;
    endcase
    flags_s = 4'b0000;
    if (!nop_s) begin
      flags_s[FLAG_N] = res_s[M];
      flags_s[FLAG_Z] = (res_s == {WIDTH{1'b0}});
      flags_s[FLAG_C] = c_s;
      flags_s[FLAG_V] = v_s;
    end else begin
      flags_s = 4'b0000;
    end
  end

  // Stage 2 result register; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= {WIDTH{1'b0}};
      tag_out   <= {TAG_W{1'b0}};
      flags_out <= 4'b0000;
    end else if (s1_advance_s) begin
      out_valid <= 1'b1;
      out       <= res_s;
      tag_out   <= s1_tag_r;
      flags_out <= flags_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: behavioural reference queue, per-cycle output
// compare, directed timing/flag cases and randomized traffic with back-pressure.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_in;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic [TW-1:0] tag_out;
  logic [3:0]    flags_out;

  int total = 0;
  int bad   = 0;
  logic [15:0] expq[$];   // {tag, flags, result}
  logic        hold_p = 1'b0;
  logic [15:0] hold_v = 16'h0000;
  logic        rand_done;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_in(op_in), .a_in(a_in), .b_in(b_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .tag_out(tag_out), .flags_out(flags_out)
  );

  // Reference: {N,Z,C,V, result} from plain integer arithmetic on 8-bit values
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r, t, sa, sb, sh, c, v;
    logic n, z;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    c = 0; v = 0; r = 0;
    case (op)
      1:  begin t = a + b; r = t % 256; c = (t > 255) ? 1 : 0;
                t = sa + sb; v = (t > 127 || t < -128) ? 1 : 0; end
      2:  begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0;
                t = sa - sb; v = (t > 127 || t < -128) ? 1 : 0; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (a << sh) % 256;
      7:  r = a >> sh;
      8:  r = (sa >>> sh) & 255;
      9:  r = (sa < sb) ? 1 : 0;
      10: r = (a < b) ? 1 : 0;
      11: r = (a * b) % 256;
      default: return 12'h000;
    endcase
    n = (r > 127);
    z = (r == 0);
    return {n, z, c[0], v[0], r[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag);
    int n;
    in_valid = 1'b1; op_in = op; a_in = a; b_in = b; tag_in = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("accept_bound", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Per-cycle compare against the reference queue, plus hold-stability under stall
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      hold_p = 1'b0;
    end else begin
      if (hold_p)
        check("hold_stable", {15'd0, out_valid, tag_out, flags_out, out}, {16'd1, hold_v});
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("stale_result", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          check("result", {16'd0, tag_out, flags_out, out}, {16'd0, expq[0]});
          void'(expq.pop_front());
        end
      end
      hold_p = out_valid && !out_ready;
      hold_v = {tag_out, flags_out, out};
      if (in_valid && in_ready)
        expq.push_back({tag_in, model(int'(op_in), int'(a_in), int'(b_in))});
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_in = 4'd0; a_in = 8'd0; b_in = 8'd0; tag_in = 4'd0; rand_done = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_flags", {28'd0, flags_out}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Hand-computed values pinning the reference model
    check("model_add_ovf", model(1, 8'h7F, 8'h01), 32'h980);
    check("model_sub_eq",  model(2, 8'h05, 8'h05), 32'h600);
    check("model_add_cz",  model(1, 8'hFF, 8'h01), 32'h600);
    check("model_sra",     model(8, 8'h80, 8'h0A), 32'h8E0);
    check("model_slt",     model(9, 8'hFF, 8'h01), 32'h001);
    check("model_sltu",    model(10, 8'hFF, 8'h01), 32'h400);
    check("model_undef",   model(15, 8'h12, 8'h34), 32'h000);
    check("model_mul",     model(11, 8'h0D, 8'h0B), 32'h88F);

    // ADD/SUB back-to-back, one result per clock
    send(4'd1, 8'h7F, 8'h01, 4'd1);
    send(4'd2, 8'h05, 8'h05, 4'd2);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_out", {20'd0, tag_out, flags_out, out}, {20'd0, 4'd1, 4'b1001, 8'h80});
    tick();
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_out", {20'd0, tag_out, flags_out, out}, {20'd0, 4'd2, 4'b0110, 8'h00});

    // Shifts, compares, undefined code
    send(4'd8, 8'h80, 8'h0A, 4'd3);
    send(4'd9, 8'hFF, 8'h01, 4'd4);
    send(4'd10, 8'hFF, 8'h01, 4'd5);
    send(4'd15, 8'hAA, 8'h55, 4'd6);
    repeat (3) tick();

    // Back-pressure: three ops, consumer stalled for five clocks
    out_ready = 1'b0;
    fork
      begin
        send(4'd5, 8'h0F, 8'hF0, 4'd3);
        send(4'd4, 8'h12, 8'h21, 4'd4);
        send(4'd6, 8'h81, 8'h09, 4'd5);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_first_tag", {28'd0, tag_out}, 32'd3);
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();

    // MUL latency, stall of a following ADD
    send(4'd11, 8'h0D, 8'h0B, 4'd6);
    in_valid = 1'b1; op_in = 4'd1; a_in = 8'd3; b_in = 8'd4; tag_in = 4'd7;
    check("mul_ready_k0", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 8) check("mul_busy_ready", 32'(in_ready), 32'd0);
      if (k == 9) check("mul_done_ready", 32'(in_ready), 32'd1);
      if (k <= 9) check("mul_no_early_out", 32'(out_valid), 32'd0);
      if (k == 10) begin
        check("mul_out", {19'd0, out_valid, tag_out, out}, {19'd0, 1'b1, 4'd6, 8'h8F});
        in_valid = 1'b0;
      end
      if (k == 11) check("add_after_mul", {19'd0, out_valid, tag_out, out}, {19'd0, 1'b1, 4'd7, 8'h07});
    end
    repeat (2) tick();

    // Reset with results in flight and consumer stalled
    out_ready = 1'b0;
    send(4'd1, 8'h10, 8'h20, 4'd9);
    send(4'd2, 8'h30, 8'h01, 4'd10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out", {16'd0, tag_out, flags_out, out}, 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Reset in the third BUSY cycle of a MUL
    send(4'd11, 8'hFF, 8'hFF, 4'd11);
    repeat (3) tick();
    check("mul_busy_state", 32'(dut.u_mul.state_r), 32'(MUL_BUSY));
    rst_n = 1'b0;
    #1;
    check("mulrst_state", 32'(dut.u_mul.state_r), 32'(MUL_IDLE));
    check("mulrst_valid", 32'(out_valid), 32'd0);
    check("mulrst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("mulrst_never_out", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      n++;
      tick();
    end
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised two-stage ALU with valid/ready handshakes, status flags, tag pass-through and an iterative shift-add multiplier. It is the successor to the fixed 6-bit add/sub ALU. It sits between the operand-issue logic and the writeback path, and adds back-pressure, full throughput for single-cycle ops and a multi-cycle MUL.

## Interface
- WIDTH, 8: operand/result width, ≥2.
- TAG_W, 4: width of the opaque tag carried with each operation.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- op_in  in  4  alu_pkg::op_t.
- a_in, b_in  in  WIDTH  operands.
- tag_in  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out  out  WIDTH  result.
- tag_out  out  TAG_W  tag of this result.
- flags_out  out  4  {N, Z, C, V}.

## Operation
- Stage 1 (S1) registers op, a, b and tag on accept. Stage 2 (S2) registers result, flags and tag.
- Ops:
  - NOP: result 0, flags 0.
  - ADD: a+b.
  - SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift a by b[$clog2(WIDTH)-1:0]. Upper bits of b are ignored.
  - SLT: signed a<b, giving 1 or 0.
  - SLTU: unsigned a<b, giving 1 or 0.
  - MUL: low WIDTH bits of the unsigned product.
  - Undefined codes behave as NOP.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - C: ADD carry-out; SUB no-borrow (a≥b unsigned); 0 otherwise.
  - V: signed overflow for ADD/SUB; 0 otherwise.
  - NOP forces all four flags to 0.
- Flow control:
  - S2 loads when S1 holds a finished op and (!out_valid || out_ready).
  - in_ready = !s1_valid || s1_advance (combinational), so a back-to-back accept occurs in the same cycle S1 drains.
  - out_ready low holds out, tag_out, flags_out and out_valid stable.
- MUL FSM states, for the op held in S1:
  - IDLE: if S1 holds MUL, go to BUSY with cnt=0 and prod=0.
  - BUSY: each cycle, if b[cnt] then prod += a<<cnt; cnt++. The edge with cnt==WIDTH-1 goes to DONE.
  - DONE: S1 may advance with result=prod. The FSM returns to IDLE on advance.
  - While S1 holds an unfinished MUL, S1 does not advance and in_ready=0.
- Single-cycle ops never wait on the FSM.

## Timing
- Reset values:
  - out_valid=0, out=0, tag_out=0, flags_out=0.
  - S1 empty, FSM IDLE, cnt=0, prod=0.
  - in_ready=1 while in reset and after it.
- Single-cycle op accepted at edge N: out_valid=1 after edge N+1, provided S2 is free.
- MUL accepted at edge N:
  - BUSY from edge N+1.
  - DONE at edge N+1+WIDTH.
  - out_valid=1 after edge N+2+WIDTH.
- Throughput: one single-cycle op per clock with out_ready=1. One MUL per WIDTH+2 clocks.
- Order: strictly in order. A single-cycle op behind a MUL waits in the input handshake.
- Simultaneous S2 drain and S1 advance in one cycle: S2 takes the new result with no bubble.
- Reset asserted mid-operation, including mid-MUL: all state clears asynchronously and the in-flight op is discarded, not completed.

## Structure
- alu_pkg holds:
  - op_t, a 4-bit enum: NOP=0, ADD=1, SUB=2, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL=11.
  - Flag bit index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
  - The mul_state_t enum.
- Sub-module alu_mul_seq contains the IDLE/BUSY/DONE FSM, cnt and prod.
  - Ports: start, a, b, done, product.
  - Parameter: WIDTH.
- alu_pipe holds S1/S2, the combinational op decode and flags, and the handshake.

## Test plan
All scenarios use WIDTH=8 unless stated.

1. Reset check: drive rst_n=0 mid-stream, then release. Required: out_valid=0, out=0, flags=0, in_ready=1; no stale result appears afterwards.
2. ADD/SUB flags, back-to-back, out_ready=1:
   - ADD 0x7F+0x01 → out=0x80, N=1, V=1, C=0.
   - SUB 0x05−0x05 → out=0x00, Z=1, C=1.
   - Each result appears 2 cycles after its accept, one per cycle.
3. Back-pressure: hold out_ready=0 for 5 cycles with 3 ops offered. Required: first result stable; in_ready=0 once S1 and S2 are full; no loss, no reorder, tags match on release.
4. MUL: 0x0D×0x0B accepted at edge N. Required: out=0x8F, out_valid after edge N+10, in_ready=0 during BUSY; a following ADD completes 2 cycles after its later accept.
5. Shifts and compares:
   - SRA 0x80 by b=0x0A → 0xE0 (shift 2).
   - SLT 0xFF,0x01 → 1.
   - SLTU 0xFF,0x01 → 0.
   - Op code 0xF → out=0, flags=0.
6. Reset mid-MUL: assert rst_n=0 in BUSY cycle 3. Required: FSM IDLE, out_valid=0, and the MUL result never appears.
